axi4_ram_slave: RTL

AXI4 full-protocol slave (INCR bursts, full-width beats) backed by on-chip dual-port RAM; responder end for uiFDMA masters, for loopback/sim and small frame buffers.

---
 rtl/axi4_ram_slave.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_ram_slave.sv
// AXI4 slave (INCR bursts, full-width beats) backed by a dual-port RAM.
// Independent write and read engines, one outstanding burst each, 1 beat/cycle.
module axi4_ram_slave #(
   parameter int S_AXI_ID_WIDTH   = 3,
   parameter int S_AXI_ADDR_WIDTH = 32,
   parameter int S_AXI_DATA_WIDTH = 128,
   parameter int MEM_DEPTH        = 1024
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);

   localparam int ADDR_LSB = $clog2(S_AXI_DATA_WIDTH / 8);
   localparam int IDX_W    = $clog2(MEM_DEPTH);
   localparam int STRB_W   = S_AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

   logic [S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   wstate_t                   wstate_q, wstate_d;
   logic                      awready_q, awready_d;
   logic                      wready_q, wready_d;
   logic                      bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic [S_AXI_ID_WIDTH-1:0] bid_q, bid_d;
   logic [IDX_W-1:0]          widx_q, widx_d;
   logic [7:0]                wlen_q, wlen_d;
   logic [7:0]                wcnt_q, wcnt_d;
   logic                      werr_q, werr_d;

   rstate_t                     rstate_q, rstate_d;
   logic                        arready_q, arready_d;
   logic                        rvalid_q, rvalid_d;
   logic                        rlast_q, rlast_d;
   logic [S_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
   logic [IDX_W-1:0]            ridx_q, ridx_d;
   logic [7:0]                  rlen_q, rlen_d;
   logic [7:0]                  rcnt_q, rcnt_d;
   logic [S_AXI_DATA_WIDTH-1:0] rdata_q;
   logic                        rd_en;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic w_last_beat, w_beat_err;
   logic unused_addr_bits;

   assign aw_hs       = awready_q & S_AXI_AWVALID;
   assign w_hs        = wready_q & S_AXI_WVALID;
   assign b_hs        = bvalid_q & S_AXI_BREADY;
   assign ar_hs       = arready_q & S_AXI_ARVALID;
   assign r_hs        = rvalid_q & S_AXI_RREADY;
   assign w_last_beat = (wcnt_q == wlen_q);
   // WLAST only grades the response; the beat counter alone ends the burst.
   assign w_beat_err  = S_AXI_WLAST ^ w_last_beat;

   assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

   always_comb begin
      wstate_d  = wstate_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      bid_d     = bid_q;
      widx_d    = widx_q;
      wlen_d    = wlen_q;
      wcnt_d    = wcnt_q;
      werr_d    = werr_q;
      case (wstate_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (aw_hs) begin
               awready_d = 1'b0;
               wready_d  = 1'b1;
               bid_d     = S_AXI_AWID;
               widx_d    = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
               wlen_d    = S_AXI_AWLEN;
               wcnt_d    = 8'd0;
               werr_d    = 1'b0;
               wstate_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               widx_d = widx_q + IDX_W'(1);
               wcnt_d = wcnt_q + 8'd1;
               werr_d = werr_q | w_beat_err;
               if (w_last_beat) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (werr_q | w_beat_err) ? 2'b10 : 2'b00;
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (b_hs) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         bid_q     <= '0;
         widx_q    <= '0;
         wlen_q    <= 8'd0;
         wcnt_q    <= 8'd0;
         werr_q    <= 1'b0;
      end else begin
         wstate_q  <= wstate_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         bid_q     <= bid_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         werr_q    <= werr_d;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (w_hs && !S_AXI_ARESET) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (S_AXI_WSTRB[b]) mem[widx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
   end

   // Prefetch: the next word is read on every non-final R handshake so RVALID never gaps.
   always_comb begin
      rstate_d  = rstate_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      ridx_d    = ridx_q;
      rlen_d    = rlen_q;
      rcnt_d    = rcnt_q;
      rd_en     = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               arready_d = 1'b0;
               rid_d     = S_AXI_ARID;
               ridx_d    = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
               rlen_d    = S_AXI_ARLEN;
               rcnt_d    = 8'd0;
               rstate_d  = R_FETCH;
            end
         end
         R_FETCH: begin
            rd_en    = 1'b1;
            ridx_d   = ridx_q + IDX_W'(1);
            rvalid_d = 1'b1;
            rlast_d  = (rlen_q == 8'd0);
            rstate_d = R_DATA;
         end
         R_DATA: begin
            if (r_hs) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  rd_en   = 1'b1;
                  ridx_d  = ridx_q + IDX_W'(1);
                  rcnt_d  = rcnt_q + 8'd1;
                  rlast_d = ((rcnt_q + 8'd1) == rlen_q);
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         ridx_q    <= '0;
         rlen_q    <= 8'd0;
         rcnt_q    <= 8'd0;
      end else begin
         rstate_q  <= rstate_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
      end
   end

   // Registered read port; a same-cycle write to this word is seen on the next read.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) rdata_q <= '0;
      else if (rd_en)   rdata_q <= mem[ridx_q];
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BID     = bid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RID     = rid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RLAST   = rlast_q;
   assign S_AXI_RVALID  = rvalid_q;

endmodule
